bram_port_arbiter: RTL and testbench

//  Shares one 32-bit port of the register-file block RAM between N_REQ requesters.

---
 rtl/bram_port_arbiter.sv | 108 ++++++++++
 tb/tb_bram_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one 32-bit BRAM port between N_REQ requesters
// Ports:
//   i_clk, i_resetn            clock, asynchronous active-low reset
//   i_req/i_req_we             per-requester request and write flag (held until o_gnt)
//   i_req_addr/i_req_wdata     packed per-requester word address and write data
//   o_gnt                      one-hot grant pulse in the command cycle
//   o_rvalid/o_rdata           one-hot read-return strobe and its data
//   o_bram_en/we/addr/din      registered BRAM command; i_bram_dout is BRAM read data
//   o_busy                     a read is still travelling through the return pipe
// Option: define PRIO0_EN to give requester 0 fixed highest priority.
module bram_port_arbiter #(
   parameter int N_REQ    = 3,
   parameter int ADDR_W   = 6,
   parameter int BRAM_LAT = 1
) (
   input  logic                    i_clk,
   input  logic                    i_resetn,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ-1:0]        i_req_we,
   input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
   input  logic [N_REQ*32-1:0]     i_req_wdata,
   output logic [N_REQ-1:0]        o_gnt,
   output logic [N_REQ-1:0]        o_rvalid,
   output logic [31:0]             o_rdata,
   output logic                    o_bram_en,
   output logic [3:0]              o_bram_we,
   output logic [31:0]             o_bram_addr,
   output logic [31:0]             o_bram_din,
   input  logic [31:0]             i_bram_dout,
   output logic                    o_busy
);
   localparam int              ID_W = $clog2(N_REQ);
   localparam logic [ID_W:0]   NQ   = (ID_W+1)'(N_REQ);
   localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ-1);
   logic [ID_W-1:0]               r_rr;
   logic [ID_W-1:0]               r_cmd_id;
   logic [BRAM_LAT-1:0]           r_pv;
   logic [BRAM_LAT-1:0][ID_W-1:0] r_pid;
   logic [N_REQ-1:0]              w_elig;
   logic [N_REQ-1:0]              w_srch;
   logic [N_REQ-1:0]              w_rot;
   logic [2*N_REQ-1:0]            w_dbl;
   logic [ID_W:0]                 w_off;
   logic [ID_W:0]                 w_sum;
   logic [ID_W-1:0]               w_rr_win;
   logic [ID_W-1:0]               w_win;
   logic [ID_W-1:0]               w_rr_nxt;
   logic                          w_p0;
   logic                          w_found;
   // a requester being granted right now is masked so its still-held req is not granted twice
   assign w_elig = i_req & ~o_gnt;
`ifdef PRIO0_EN
   assign w_p0   = w_elig[0];
   assign w_srch = w_elig & ~N_REQ'(1);
`else
   assign w_p0   = 1'b0;
   assign w_srch = w_elig;
`endif
   assign w_found = |w_elig;
   // rotate the eligible set so that bit 0 is the requester at rr, then take the lowest set bit
   assign w_dbl = {w_srch, w_srch};
   assign w_rot = w_dbl[r_rr +: N_REQ];
   always_comb begin
      w_off = '0;
      for (int k = N_REQ-1; k >= 0; k--)
         if (w_rot[k]) w_off = (ID_W+1)'(k);
   end
   assign w_sum    = {1'b0, r_rr} + w_off;
   assign w_rr_win = (w_sum >= NQ) ? ID_W'(w_sum - NQ) : w_sum[ID_W-1:0];
   assign w_win    = w_p0 ? '0 : w_rr_win;
   assign w_rr_nxt = (w_win == LAST) ? '0 : w_win + ID_W'(1);
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_rr        <= '0;
         r_cmd_id    <= '0;
         r_pv        <= '0;
         r_pid       <= '0;
         o_gnt       <= '0;
         o_rvalid    <= '0;
         o_rdata     <= '0;
         o_bram_en   <= 1'b0;
         o_bram_we   <= '0;
         o_bram_addr <= '0;
         o_bram_din  <= '0;
      end else begin
         o_gnt     <= w_found ? N_REQ'(1) << w_win : '0;
         o_bram_en <= w_found;
         o_bram_we <= {4{w_found & i_req_we[w_win]}};
         if (w_found) begin
            o_bram_addr <= {{(30-ADDR_W){1'b0}}, i_req_addr[w_win*ADDR_W +: ADDR_W], 2'b00};
            o_bram_din  <= i_req_wdata[w_win*32 +: 32];
            r_cmd_id    <= w_win;
            // a priority grant to requester 0 leaves the rotation where it was
            if (!w_p0) r_rr <= w_rr_nxt;
         end
         // return pipe: the tail entry lines up with i_bram_dout being valid
         r_pv[0]  <= o_bram_en & ~o_bram_we[0];
         r_pid[0] <= r_cmd_id;
         for (int k = 1; k < BRAM_LAT; k++) begin
            r_pv[k]  <= r_pv[k-1];
            r_pid[k] <= r_pid[k-1];
         end
         o_rvalid <= r_pv[BRAM_LAT-1] ? N_REQ'(1) << r_pid[BRAM_LAT-1] : '0;
         if (r_pv[BRAM_LAT-1]) o_rdata <= i_bram_dout;
      end
   end
   assign o_busy = |r_pv;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: scoreboard bench for bram_port_arbiter with a 1-cycle BRAM model
module tb_bram_port_arbiter;
   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] data;
   } rd_t;
   logic        clk = 1'b0;
   logic        resetn;
   logic [2:0]  req, req_we, gnt, rvalid;
   logic [17:0] req_addr;
   logic [95:0] req_wdata;
   logic [31:0] rdata, bram_addr, bram_din, bram_dout;
   logic [3:0]  bram_we;
   logic        bram_en, busy;
   logic [31:0] mem [64];
   logic [63:0] wr = '0;
   logic [31:0] ref_mem [64];
   rd_t         exp_rd[$];
   int          exp_gnt[$];
   rd_t         mon_e;
   int          n_chk = 0;
   int          n_err = 0;
`ifdef PRIO0_EN
   int          ord[6] = '{0, 1, 0, 2, 0, 1};
`else
   int          ord[6] = '{0, 1, 2, 0, 1, 2};
`endif

   bram_port_arbiter dut (
      .i_clk(clk), .i_resetn(resetn), .i_req(req), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_gnt(gnt), .o_rvalid(rvalid),
      .o_rdata(rdata), .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
      .o_bram_din(bram_din), .i_bram_dout(bram_dout), .o_busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      return i == 5 ? 32'hDEADBEEF : i == 1 ? 32'hA : i == 2 ? 32'hB : 32'h1000_0000 + 32'(i);
   endfunction

   always @(posedge clk)
      if (bram_en) begin
         if (bram_we == 4'hF) begin
            mem[bram_addr[7:2]] <= bram_din;
            wr[bram_addr[7:2]]  <= 1'b1;
         end
         bram_dout <= wr[bram_addr[7:2]] ? mem[bram_addr[7:2]] : init_val(int'(bram_addr[7:2]));
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (|gnt) begin
         if (exp_gnt.size() == 0) check("gnt_unexp", 32'(gnt), 0);
         else check("gnt_id", 32'(gnt), 32'(3'b001 << exp_gnt.pop_front()));
      end
      if (|rvalid) begin
         if (exp_rd.size() == 0) check("rv_unexp", 32'(rvalid), 0);
         else begin
            mon_e = exp_rd.pop_front();
            check("rv_id", 32'(rvalid), 32'(3'b001 << mon_e.id));
            check("rv_data", rdata, mon_e.data);
         end
      end
   end

   task automatic issue(input int id, input logic we, input logic [5:0] a, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      exp_gnt.push_back(id);
      if (!we) exp_rd.push_back(rd_t'{2'(id), ref_mem[a]});
      req_we[id] = we;
      req_addr[id*6 +: 6] = a;
      req_wdata[id*32 +: 32] = d;
      req[id] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!gnt[id] && n < 32);
      req[id] = 1'b0;
      check("gnt_seen", 32'(gnt[id]), 1);
      if (gnt[id]) begin
         check("cmd_en", 32'(bram_en), 1);
         check("cmd_we", 32'(bram_we), we ? 32'hF : 32'h0);
         check("cmd_addr", bram_addr, {24'h0, a, 2'b00});
         if (we) begin
            check("cmd_din", bram_din, d);
            ref_mem[a] = d;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_rd.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_rd.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req = '0;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      req = '0;
      req_we = '0;
      req_addr = '0;
      req_wdata = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rdata", rdata, 0);
      check("rst_en", 32'(bram_en), 0);
      check("rst_we", 32'(bram_we), 0);
      check("rst_addr", bram_addr, 0);
      check("rst_din", bram_din, 0);
      check("rst_busy", 32'(busy), 0);
      resetn = 1'b1;
      // contention: all three write continuously, grant order follows the rotation
      @(negedge clk);
      for (int i = 0; i < 6; i++) exp_gnt.push_back(ord[i]);
      req_we = 3'b111;
      req_addr = {6'h12, 6'h11, 6'h10};
      req_wdata = {32'hC2, 32'hC1, 32'hC0};
      req = 3'b111;
      repeat (6) @(negedge clk);
      req = '0;
      for (int i = 0; i < 3; i++) ref_mem[16+i] = 32'hC0 + 32'(i);
      repeat (2) @(negedge clk);
      check("cont_left", exp_gnt.size(), 0);
      // single read with latency check
      do_reset();
      issue(1, 1'b0, 6'h05, 0);
      @(negedge clk);
      check("busy_rd", 32'(busy), 1);
      check("rv_early", 32'(rvalid), 0);
      @(negedge clk);
      check("rv_lat", 32'(rvalid), 32'b010);
      drain();
      // write then read of the top word
      issue(0, 1'b1, 6'h3F, 32'h12345678);
      issue(0, 1'b0, 6'h3F, 0);
      drain();
      // pipelined reads from two requesters
      do_reset();
      @(negedge clk);
      exp_gnt.push_back(1);
      exp_gnt.push_back(2);
      exp_rd.push_back(rd_t'{2'd1, ref_mem[1]});
      exp_rd.push_back(rd_t'{2'd2, ref_mem[2]});
      req_we = '0;
      req_addr[6 +: 6] = 6'h01;
      req_addr[12 +: 6] = 6'h02;
      req = 3'b110;
      @(negedge clk);
      check("p_g1", 32'(gnt), 32'b010);
      req[1] = 1'b0;
      @(negedge clk);
      check("p_g2", 32'(gnt), 32'b100);
      check("p_busy", 32'(busy), 1);
      req[2] = 1'b0;
      @(negedge clk);
      check("p_rv1", 32'(rvalid), 32'b010);
      @(negedge clk);
      check("p_rv2", 32'(rvalid), 32'b100);
      drain();
      // withdrawn request never gets a grant
      @(negedge clk);
      exp_gnt.push_back(0);
      exp_rd.push_back(rd_t'{2'd0, ref_mem[5]});
      req_addr[0 +: 6] = 6'h05;
      req = 3'b101;
      @(negedge clk);
      check("w_g0", 32'(gnt), 32'b001);
      req = '0;
      repeat (4) @(negedge clk);
      drain();
      check("w_left", exp_gnt.size(), 0);
      // reset while a read is in flight
      issue(1, 1'b0, 6'h01, 0);
      @(negedge clk);
      resetn = 1'b0;
      exp_rd.delete();
      #1;
      check("mr_gnt", 32'(gnt), 0);
      check("mr_rvalid", 32'(rvalid), 0);
      check("mr_rdata", rdata, 0);
      check("mr_en", 32'(bram_en), 0);
      check("mr_we", 32'(bram_we), 0);
      check("mr_addr", bram_addr, 0);
      check("mr_din", bram_din, 0);
      check("mr_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      exp_gnt.push_back(0);
      exp_gnt.push_back(2);
      exp_rd.push_back(rd_t'{2'd0, ref_mem[2]});
      exp_rd.push_back(rd_t'{2'd2, ref_mem[5]});
      req_addr[0 +: 6] = 6'h02;
      req_addr[12 +: 6] = 6'h05;
      req = 3'b101;
      resetn = 1'b1;
      @(negedge clk);
      check("r_g0", 32'(gnt), 32'b001);
      req[0] = 1'b0;
      @(negedge clk);
      check("r_g2", 32'(gnt), 32'b100);
      req[2] = 1'b0;
      drain();
      repeat (2) @(negedge clk);
      check("gnt_left", exp_gnt.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
